// File: rtl/clock_btn_cond.sv
// Push-button conditioner for the CLOCK core: per-button synchroniser, debouncer and
// press/auto-repeat pulse generator producing single-cycle set_* pulses.
module clock_btn_cond #(
  parameter int                 N_BTN        = 3,
  parameter int                 DEB_CYCLES   = 16,
  parameter int                 REPEAT_DELAY = 64,
  parameter int                 REPEAT_RATE  = 16,
  parameter logic [N_BTN-1:0]   RPT_MASK     = N_BTN'(3'b011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] pulse_o,
  output logic [N_BTN-1:0] level_o
);

  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  // Holds at all-ones so a non-repeating button can stay pressed indefinitely.
  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;

  // Stage p0/p1: two-flop synchroniser on the raw asynchronous levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_i;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t          state, state_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic [RW-1:0]   rcnt, rcnt_nxt;
    logic            deb_p2, deb_nxt;
    logic            pulse_p2, pulse_nxt;
    logic            rise, fall;

    // Stage p2: debounce; rise/fall fire on the same edge the stable level changes
    always_comb begin
      deb_nxt  = deb_p2;
      dcnt_nxt = '0;
      rise     = 1'b0;
      fall     = 1'b0;
      if (sync_p1[i] != deb_p2) begin
        if (dcnt == DW'(DEB_CYCLES - 1)) begin
          deb_nxt = sync_p1[i];
          rise    = sync_p1[i];
          fall    = ~sync_p1[i];
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
    end

    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      pulse_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (fall) begin
            rcnt_nxt  = '0;
            state_nxt = IDLE;
          end else if (RPT_MASK[i] && rcnt == RW'(REPEAT_DELAY - 1)) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = RPT;
          end else begin
            rcnt_nxt = sat_inc(rcnt);
          end
        end
        RPT: begin
          // Release takes precedence over a coincident repeat tick.
          if (fall) begin
            rcnt_nxt  = '0;
            state_nxt = IDLE;
          end else if (rcnt == RW'(REPEAT_RATE - 1)) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = sat_inc(rcnt);
          end
        end
        default: begin
          rcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        dcnt     <= '0;
        rcnt     <= '0;
        deb_p2   <= 1'b0;
        pulse_p2 <= 1'b0;
      end else begin
        state    <= state_nxt;
        dcnt     <= dcnt_nxt;
        rcnt     <= rcnt_nxt;
        deb_p2   <= deb_nxt;
        pulse_p2 <= pulse_nxt;
      end
    end

    assign level_o[i] = deb_p2;
    assign pulse_o[i] = pulse_p2;
  end

endmodule

// File: tb/tb_clock_btn_cond.sv
// Bench for clock_btn_cond: directed button scenarios plus random bouncy traffic,
// compared each cycle against a sample-window / time-since-press reference model.
module tb_clock_btn_cond;

  localparam int         N     = 3;
  localparam int         DEB   = 4;
  localparam int         DELAY = 8;
  localparam int         RATE  = 3;
  localparam logic [2:0] MASK  = 3'b011;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] pulse_o;
  logic [N-1:0] level_o;

  clock_btn_cond #(
    .N_BTN(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(DELAY),
    .REPEAT_RATE(RATE), .RPT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .pulse_o(pulse_o), .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: stable level flips when the last DEB synchronised samples
  // (raw samples two edges old) all disagree with it; pulses are scheduled
  // from the number of edges elapsed since the press.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_deb, m_pulse, m_held;
  int           m_t[N];

  task automatic model_edge(input logic [N-1:0] b, input logic r);
    logic [N-1:0] h;
    logic         flip;
    if (r) begin
      hist.delete();
      repeat (DEB + 2) hist.push_back('0);
      m_deb = '0; m_pulse = '0; m_held = '0;
      for (int i = 0; i < N; i++) m_t[i] = 0;
    end else begin
      hist.push_back(b);
      void'(hist.pop_front());
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          h = hist[hist.size() - 3 - j];
          if (h[i] == m_deb[i]) flip = 1'b0;
        end
        m_pulse[i] = 1'b0;
        if (flip) begin
          m_deb[i] = ~m_deb[i];
          if (m_deb[i]) begin
            m_pulse[i] = 1'b1;
            m_held[i]  = 1'b1;
            m_t[i]     = 0;
          end else begin
            m_held[i]  = 1'b0;
          end
        end else if (m_held[i]) begin
          m_t[i]++;
          if (MASK[i] && (m_t[i] == DELAY ||
              (m_t[i] > DELAY && (m_t[i] - DELAY) % RATE == 0)))
            m_pulse[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic [N-1:0] b, input logic r);
    @(negedge clk);
    btn = b;
    rst = r;
    if (r) begin
      #1;
      chk("rst_async_pulse", pulse_o, '0);
      chk("rst_async_level", level_o, '0);
    end
    @(posedge clk);
    #1;
    model_edge(b, r);
    chk("model_pulse", pulse_o, m_pulse);
    chk("model_level", level_o, m_deb);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b0);
  endtask

  int           cnt;
  logic [N-1:0] cur, glitch;

  initial begin
    rst = 1'b1;
    btn = N'($urandom);
    model_edge('0, 1'b1);

    // Reset with random buttons, then one cycle after release
    for (int k = 0; k < 6; k++) cycle(N'($urandom), 1'b1);
    cycle(N'($urandom), 1'b0);
    chk("t1_post_rst_pulse", pulse_o, '0);
    chk("t1_post_rst_level", level_o, '0);
    idle(12);

    // Non-repeating button held: one press pulse only
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(3'b100, 1'b0);
      cnt += int'(pulse_o[2]);
      if (k == 4) chk("t2_level_before", level_o, 3'b000);
      if (k == 5) begin
        chk("t2_press", pulse_o, 3'b100);
        chk("t2_level", level_o, 3'b100);
      end
    end
    for (int k = 0; k < 12; k++) begin
      cycle('0, 1'b0);
      cnt += int'(pulse_o[2]);
    end
    chk_int("t2_pulse_count", cnt, 1);

    // Repeating button held then released
    for (int k = 0; k < 30; k++) begin
      cycle(3'b001, 1'b0);
      if (k == 5 || k == 13 || k == 16 || k == 19) chk("t3_pulse", pulse_o, 3'b001);
      if (k == 6 || k == 12 || k == 14) chk("t3_no_pulse", pulse_o, 3'b000);
    end
    for (int k = 0; k < 12; k++) begin
      cycle('0, 1'b0);
      if (k == 4) chk("t3_level_held", level_o, 3'b001);
      if (k == 5) chk("t3_level_fall", level_o, 3'b000);
    end

    // Bouncing faster than the debounce window never registers
    for (int k = 0; k < 24; k++) begin
      cycle(((k / 2) % 2 == 0) ? 3'b010 : 3'b000, 1'b0);
      chk("t4_no_pulse", pulse_o, 3'b000);
      chk("t4_no_level", level_o, 3'b000);
    end
    idle(12);

    // Simultaneous presses pulse together and repeat in lockstep
    for (int k = 0; k < 20; k++) begin
      cycle(3'b011, 1'b0);
      if (k == 5 || k == 13 || k == 16 || k == 19) chk("t5_pair", pulse_o, 3'b011);
    end
    idle(12);

    // Reset mid-hold, button still held afterwards
    for (int k = 0; k < 15; k++) cycle(3'b001, 1'b0);
    cycle(3'b001, 1'b1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(3'b001, 1'b0);
      cnt += int'(pulse_o[0]);
      if (k == 5) chk("t6_fresh_press", pulse_o, 3'b001);
    end
    chk_int("t6_pulse_count", cnt, 1);
    idle(12);

    // Random bouncy traffic with occasional resets
    cur = '0;
    for (int k = 0; k < 600; k++) begin
      glitch = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) cur[i] = ~cur[i];
        if ($urandom_range(0, 15) == 0) glitch[i] = 1'b1;
      end
      cycle(cur ^ glitch, ($urandom_range(0, 199) == 0));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
